// File: rtl/btn_input_reader.sv
`default_nettype none
// ============================================================================
// Module   : btn_input_reader
// Brief    : Two-channel button front end: sync, debounce, press/release/long
//            pulses and a shared 4-bit press counter.
// Revision : 1.0
// ============================================================================
module btn_input_reader #(
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int LONG_CYCLES     = 500000
) (
  input  logic       clk_half_mhz,
  input  logic       reset,
  input  logic [1:0] btn_n,
  output logic [1:0] btn_level,
  output logic [1:0] btn_press,
  output logic [1:0] btn_release,
  output logic [1:0] btn_long,
  output logic [3:0] press_count
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_DB_PRESS   = 2'd1,
    S_HELD       = 2'd2,
    S_DB_RELEASE = 2'd3
  } state_t;

  localparam logic [12:0] C_DB_LAST   = 13'(DEBOUNCE_CYCLES - 1);
  localparam logic [18:0] C_LONG      = 19'(LONG_CYCLES);
  localparam logic [18:0] C_LONG_LAST = 19'(LONG_CYCLES - 1);

  // Synchronizer carries the raw active-low level, so its reset value 1 means released.
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] pressed_s;
  logic [3:0] count_q, count_d;

  always_ff @(posedge clk_half_mhz) begin
    if (reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_s = ~sync2_q;

  for (genvar g = 0; g < 2; g++) begin : g_chan
    state_t      state_q, state_d;
    logic [12:0] dcnt_q, dcnt_d;
    logic [18:0] hcnt_q, hcnt_d;
    logic        level_q, level_d;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic        long_q, long_d;

    always_ff @(posedge clk_half_mhz) begin
      if (reset) begin
        state_q   <= S_IDLE;
        dcnt_q    <= '0;
        hcnt_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        dcnt_q    <= dcnt_d;
        hcnt_q    <= hcnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      hcnt_d    = hcnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;

      // Hold progress keeps running through release debounce so a glitch cannot lose it.
      if ((state_q == S_HELD || state_q == S_DB_RELEASE) && hcnt_q != C_LONG) begin
        hcnt_d = hcnt_q + 19'd1;
        long_d = (hcnt_q == C_LONG_LAST);
      end

      case (state_q)
        S_IDLE: begin
          if (pressed_s[g]) begin
            state_d = S_DB_PRESS;
            dcnt_d  = '0;
          end
        end
        S_DB_PRESS: begin
          if (!pressed_s[g]) begin
            state_d = S_IDLE;
          end else if (dcnt_q == C_DB_LAST) begin
            state_d = S_HELD;
            level_d = 1'b1;
            press_d = 1'b1;
            hcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + 13'd1;
          end
        end
        S_HELD: begin
          if (!pressed_s[g]) begin
            state_d = S_DB_RELEASE;
            dcnt_d  = '0;
          end
        end
        S_DB_RELEASE: begin
          if (pressed_s[g]) begin
            state_d = S_HELD;
          end else if (dcnt_q == C_DB_LAST) begin
            state_d   = S_IDLE;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            dcnt_d = dcnt_q + 13'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
    assign btn_long[g]    = long_q;
  end

  assign count_d = count_q + {3'b000, btn_press[0]} + {3'b000, btn_press[1]};

  always_ff @(posedge clk_half_mhz) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign press_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_input_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_btn_input_reader
// Brief    : Scenario tasks plus randomized traffic against a run-length model.
// Revision : 1.0
// ============================================================================
module tb_btn_input_reader;

  localparam int P_DB   = 8;
  localparam int P_LONG = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btn_n = 2'b11;
  logic [1:0] btn_level, btn_press, btn_release, btn_long;
  logic [3:0] press_count;

  btn_input_reader #(
    .DEBOUNCE_CYCLES(P_DB),
    .LONG_CYCLES    (P_LONG)
  ) dut (
    .clk_half_mhz(clk),
    .reset       (reset),
    .btn_n       (btn_n),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .press_count (press_count)
  );

  always #1000 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int t_press0, t_long;

  // Model: the level flips once the sampled input has disagreed with it for
  // DEBOUNCE+1 consecutive edges; hold age counts edges while the level is 1.
  logic [1:0] m_sync1 = '0, m_sync2 = '0;
  logic [1:0] m_level = '0, m_press = '0, m_release = '0, m_long = '0, m_prev_press = '0;
  int         m_run[2] = '{0, 0};
  int         m_age[2] = '{0, 0};
  int         m_count = 0;
  logic [7:0] obs, exp;

  task automatic model_edge(input logic [1:0] b, input logic r);
    m_prev_press = m_press;
    if (r) begin
      m_sync1 = '0; m_sync2 = '0; m_level = '0;
      m_press = '0; m_release = '0; m_long = '0; m_count = 0;
      for (int ch = 0; ch < 2; ch++) begin m_run[ch] = 0; m_age[ch] = 0; end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        m_press[ch] = 1'b0; m_release[ch] = 1'b0; m_long[ch] = 1'b0;
        if (m_level[ch] && m_age[ch] < P_LONG) begin
          m_age[ch]++;
          if (m_age[ch] == P_LONG) m_long[ch] = 1'b1;
        end
        if (m_sync2[ch] != m_level[ch]) m_run[ch]++;
        else m_run[ch] = 0;
        if (m_run[ch] == P_DB + 1) begin
          m_run[ch] = 0;
          m_level[ch] = ~m_level[ch];
          if (m_level[ch]) begin
            m_press[ch] = 1'b1;
            m_age[ch] = 0;
            m_count = (m_count + 1) % 16;
          end else begin
            m_release[ch] = 1'b1;
          end
        end
      end
      m_sync2 = m_sync1;
      m_sync1 = ~b;
    end
  endtask

  task automatic tick(input logic [1:0] b, input logic r);
    @(negedge clk);
    btn_n = b;
    reset = r;
    @(posedge clk);
    model_edge(b, r);
    cyc++;
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 6; i++) begin
      tick(2'b11, i < 3);
      n_vec++;
      if ({btn_level, btn_press, btn_release, btn_long, press_count} !== 12'h000) begin
        n_miss++;
        $display("FAIL reset_outputs cyc=%0d got %h want 000", cyc,
                 {btn_level, btn_press, btn_release, btn_long, press_count});
      end
    end
  endtask

  task automatic test_press;
    for (int i = 0; i < 16; i++) begin
      tick(2'b10, 1'b0);
      obs = {btn_level, btn_press, btn_release, btn_long};
      exp = {m_level, m_press, m_release, m_long};
      n_vec++;
      if (obs !== exp) begin n_miss++; $display("FAIL press_model cyc=%0d got %b want %b", cyc, obs, exp); end
      n_vec++;
      if (btn_press[0] !== (i == 10)) begin
        n_miss++; $display("FAIL press0_timing i=%0d got %b want %b", i, btn_press[0], (i == 10));
      end
      if (btn_press[0]) t_press0 = cyc;
    end
    n_vec++;
    if (btn_level[0] !== 1'b1) begin n_miss++; $display("FAIL press0_level got %b want 1", btn_level[0]); end
    n_vec++;
    if (press_count !== 4'd1) begin n_miss++; $display("FAIL press0_count got %0d want 1", press_count); end
  endtask

  task automatic test_glitch;
    for (int i = 0; i < 17; i++) begin
      tick((i < 5) ? 2'b00 : 2'b10, 1'b0);
      obs = {btn_level, btn_press, btn_release, btn_long};
      exp = {m_level, m_press, m_release, m_long};
      n_vec++;
      if (obs !== exp) begin n_miss++; $display("FAIL glitch_model cyc=%0d got %b want %b", cyc, obs, exp); end
      n_vec++;
      if ({btn_level[1], btn_press[1], btn_release[1]} !== 3'b000) begin
        n_miss++; $display("FAIL glitch_ch1 cyc=%0d got %b want 000", cyc,
                           {btn_level[1], btn_press[1], btn_release[1]});
      end
    end
    n_vec++;
    if (press_count !== 4'd1) begin n_miss++; $display("FAIL glitch_count got %0d want 1", press_count); end
  endtask

  task automatic test_long;
    int n_long = 0;
    for (int i = 0; i < 60; i++) begin
      tick(2'b10, 1'b0);
      obs = {btn_level, btn_press, btn_release, btn_long};
      exp = {m_level, m_press, m_release, m_long};
      n_vec++;
      if (obs !== exp) begin n_miss++; $display("FAIL long_model cyc=%0d got %b want %b", cyc, obs, exp); end
      if (btn_long[0]) begin n_long++; t_long = cyc; end
    end
    n_vec++;
    if (n_long !== 1) begin n_miss++; $display("FAIL long_pulses got %0d want 1", n_long); end
    n_vec++;
    if (t_long - t_press0 !== P_LONG) begin
      n_miss++; $display("FAIL long_delay got %0d want %0d", t_long - t_press0, P_LONG);
    end
    for (int i = 0; i < 14; i++) begin
      tick(2'b11, 1'b0);
      obs = {btn_level, btn_press, btn_release, btn_long};
      exp = {m_level, m_press, m_release, m_long};
      n_vec++;
      if (obs !== exp) begin n_miss++; $display("FAIL release_model cyc=%0d got %b want %b", cyc, obs, exp); end
      n_vec++;
      if (btn_release[0] !== (i == 10)) begin
        n_miss++; $display("FAIL release0_timing i=%0d got %b want %b", i, btn_release[0], (i == 10));
      end
    end
    n_vec++;
    if (btn_level[0] !== 1'b0) begin n_miss++; $display("FAIL release0_level got %b want 0", btn_level[0]); end
  endtask

  task automatic test_held_glitch;
    logic [1:0] pat;
    for (int i = 0; i < 54; i++) begin
      pat = (i < 16) ? 2'b10 : (i < 20) ? 2'b11 : (i < 40) ? 2'b10 : 2'b11;
      tick(pat, 1'b0);
      obs = {btn_level, btn_press, btn_release, btn_long};
      exp = {m_level, m_press, m_release, m_long};
      n_vec++;
      if (obs !== exp) begin n_miss++; $display("FAIL heldglitch_model cyc=%0d got %b want %b", cyc, obs, exp); end
      if (i >= 16 && i < 40) begin
        n_vec++;
        if ({btn_level[0], btn_press[0], btn_release[0]} !== 3'b100) begin
          n_miss++; $display("FAIL heldglitch_ch0 i=%0d got %b want 100", i,
                             {btn_level[0], btn_press[0], btn_release[0]});
        end
      end
    end
  endtask

  task automatic test_simul_count;
    int pairs = 0;
    while (m_count != 14 && pairs < 20) begin
      pairs++;
      for (int i = 0; i < 24; i++) begin
        tick((i < 12) ? 2'b10 : 2'b11, 1'b0);
        obs = {btn_level, btn_press, btn_release, btn_long};
        exp = {m_level, m_press, m_release, m_long};
        n_vec++;
        if (obs !== exp) begin n_miss++; $display("FAIL count_fill cyc=%0d got %b want %b", cyc, obs, exp); end
      end
    end
    n_vec++;
    if (press_count !== 4'd14) begin n_miss++; $display("FAIL count_14 got %0d want 14", press_count); end
    for (int i = 0; i < 28; i++) begin
      tick((i < 14) ? 2'b00 : 2'b11, 1'b0);
      obs = {btn_level, btn_press, btn_release, btn_long};
      exp = {m_level, m_press, m_release, m_long};
      n_vec++;
      if (obs !== exp) begin n_miss++; $display("FAIL both_model cyc=%0d got %b want %b", cyc, obs, exp); end
      n_vec++;
      if (btn_press !== ((i == 10) ? 2'b11 : 2'b00)) begin
        n_miss++; $display("FAIL both_press i=%0d got %b want %b", i, btn_press, (i == 10) ? 2'b11 : 2'b00);
      end
      if (i == 13) begin
        n_vec++;
        if (press_count !== 4'd0) begin n_miss++; $display("FAIL count_wrap got %0d want 0", press_count); end
      end
    end
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 24; i++) begin
        tick((i < 12) ? 2'b01 : 2'b11, 1'b0);
        obs = {btn_level, btn_press, btn_release, btn_long};
        exp = {m_level, m_press, m_release, m_long};
        n_vec++;
        if (obs !== exp) begin n_miss++; $display("FAIL pairs_model cyc=%0d got %b want %b", cyc, obs, exp); end
      end
    end
    n_vec++;
    if (press_count !== 4'd8) begin n_miss++; $display("FAIL count_8 got %0d want 8", press_count); end
  endtask

  task automatic test_reset_abort;
    // Reset during DB_PRESS, then during HELD, with the button held throughout.
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < ((phase == 0) ? 6 : 20); i++) begin
        tick(2'b10, 1'b0);
        obs = {btn_level, btn_press, btn_release, btn_long};
        exp = {m_level, m_press, m_release, m_long};
        n_vec++;
        if (obs !== exp) begin n_miss++; $display("FAIL abort_model cyc=%0d got %b want %b", cyc, obs, exp); end
      end
      tick(2'b10, 1'b1);
      n_vec++;
      if ({btn_level, btn_press, btn_release, btn_long, press_count} !== 12'h000) begin
        n_miss++; $display("FAIL abort_reset phase=%0d got %h want 000", phase,
                           {btn_level, btn_press, btn_release, btn_long, press_count});
      end
      for (int i = 0; i < 14; i++) begin
        tick(2'b10, 1'b0);
        n_vec++;
        if ({btn_press[0], btn_release[0]} !== {(i == 10), 1'b0}) begin
          n_miss++; $display("FAIL abort_repress i=%0d got %b want %b", i,
                             {btn_press[0], btn_release[0]}, {(i == 10), 1'b0});
        end
      end
    end
    for (int i = 0; i < 14; i++) begin
      tick(2'b11, 1'b0);
      obs = {btn_level, btn_press, btn_release, btn_long};
      exp = {m_level, m_press, m_release, m_long};
      n_vec++;
      if (obs !== exp) begin n_miss++; $display("FAIL abort_release cyc=%0d got %b want %b", cyc, obs, exp); end
    end
  endtask

  task automatic test_random;
    logic [1:0] val = 2'b11;
    int         dur[2] = '{0, 0};
    logic       r;
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (dur[ch] == 0) begin
          val[ch] = 1'($urandom_range(0, 1));
          dur[ch] = $urandom_range(1, 24);
        end
        dur[ch]--;
      end
      r = ($urandom_range(0, 399) == 0);
      tick(val, r);
      obs = {btn_level, btn_press, btn_release, btn_long};
      exp = {m_level, m_press, m_release, m_long};
      n_vec++;
      if (obs !== exp) begin n_miss++; $display("FAIL random_model cyc=%0d got %b want %b", cyc, obs, exp); end
      if (m_press == 2'b00 && m_prev_press == 2'b00) begin
        n_vec++;
        if (press_count !== 4'(m_count)) begin
          n_miss++; $display("FAIL random_count cyc=%0d got %0d want %0d", cyc, press_count, m_count);
        end
      end
    end
  endtask

  initial begin
    #(64'd100_000_000);
    $display("FAIL watchdog cyc=%0d got timeout want finish", cyc);
    $fatal(1);
  end

  initial begin
    test_reset;
    test_press;
    test_glitch;
    test_long;
    test_held_glitch;
    test_simul_count;
    test_reset_abort;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
